// File: rtl/capture_pkg.sv
// capture_pkg: shared types and defaults for the capture readout path
// DUMP_HEADER_EN adds the two header states to the dump state enum
package capture_pkg;
  localparam int DEPTH_DEF = 384;
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 8;
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam logic [1:0] CH_INVALID = 2'd3;
  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    WAIT_TX,
`ifdef DUMP_HEADER_EN
    DONE,
    HDR0,
    HDR1
`else
    DONE
`endif
  } dump_state_t;
endpackage

// File: rtl/dump_addr_ctr.sv
// dump_addr_ctr: loadable read address counter wrapping DEPTH-1 -> 0
module dump_addr_ctr
  import capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] start,
  input  logic          inc,
  output logic [AW-1:0] addr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) addr <= '0;
    else if (load) addr <= start;
    else if (inc) addr <= addr == AW'(DEPTH - 1) ? '0 : addr + 1'b1;
endmodule

// File: rtl/capture_dump.sv
// capture_dump: streams a captured trace oldest-first, byte by byte, to the UART transmitter
// DUMP_HEADER_EN prepends a sync byte and the channel number to every dump
module capture_dump
  import capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump,
  input  logic [1:0]    ch_sel,
  input  logic [AW-1:0] trace_end,
  output logic [AW-1:0] ram_addr,
  output logic [2:0]    ram_en,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          busy,
  output logic          dump_done,
  output logic          dump_err
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  dump_state_t state;
  logic [AW-1:0] cnt, start;
  logic [1:0] ch;
  logic accept, last, inc;
  assign accept = state == IDLE && dump && ch_sel != CH_INVALID;
  assign last = cnt == LAST;
  assign inc = state == WAIT_TX && tx_done && !last;
  // oldest sample sits one past the last written address
  assign start = trace_end == LAST ? '0 : trace_end + 1'b1;
  dump_addr_ctr #(.DEPTH(DEPTH), .AW(AW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .start(start),
    .inc(inc),
    .addr(ram_addr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      tx_data <= '0;
      ram_en <= '0;
      trmt <= 1'b0;
      busy <= 1'b0;
      dump_done <= 1'b0;
      dump_err <= 1'b0;
    end else begin
      ram_en <= '0;
      trmt <= 1'b0;
      dump_done <= 1'b0;
      dump_err <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            ch <= ch_sel;
            cnt <= '0;
            busy <= 1'b1;
`ifdef DUMP_HEADER_EN
            tx_data <= DW'(HDR_SYNC);
            trmt <= 1'b1;
            state <= HDR0;
`else
            ram_en <= 3'(1) << ch_sel;
            state <= RD;
`endif
          end else dump_err <= dump && ch_sel == CH_INVALID;
`ifdef DUMP_HEADER_EN
        HDR0:
          if (tx_done) begin
            tx_data <= DW'(ch);
            trmt <= 1'b1;
            state <= HDR1;
          end
        HDR1:
          if (tx_done) begin
            ram_en <= 3'(1) << ch;
            state <= RD;
          end
`endif
        RD: state <= LAT;
        LAT: begin
          tx_data <= ram_rdata;
          trmt <= 1'b1;
          state <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX:
          if (tx_done) begin
            if (last) begin
              dump_done <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
              ram_en <= 3'(1) << ch;
              state <= RD;
            end
          end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_capture_dump.sv
// tb_capture_dump: scoreboard bench for capture_dump with a RAM model and a UART responder
// build with DUMP_HEADER_EN to expect the two header bytes
module tb_capture_dump;
  logic clk, rst, dump, trmt, tx_done, busy, dump_done, dump_err;
  logic [1:0] ch_sel;
  logic [8:0] trace_end, ram_addr;
  logic [2:0] ram_en;
  logic [7:0] ram_rdata, tx_data;
  typedef struct {
    logic [8:0] addr;
    logic [2:0] en;
  } rd_t;
  rd_t rd_q[$];
  logic [7:0] byte_q[$];
  int n_cmp = 0, n_bad = 0;
`ifdef DUMP_HEADER_EN
  localparam int NBYTES = 386;
`else
  localparam int NBYTES = 384;
`endif

  capture_dump dut (
    .clk(clk), .rst(rst), .dump(dump), .ch_sel(ch_sel), .trace_end(trace_end),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_rdata(ram_rdata), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .busy(busy), .dump_done(dump_done), .dump_err(dump_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem(input logic [1:0] c, input logic [8:0] a);
    return 8'(int'(a) * 7 + int'(c) * 61 + 3);
  endfunction

  // registered sample RAMs; the enable picks which channel answers
  always @(posedge clk)
    if (ram_en != 0) ram_rdata <= mem(ram_en[2] ? 2'd2 : ram_en[1] ? 2'd1 : 2'd0, ram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic start_dump(input logic [8:0] te, input logic [1:0] c);
    int s;
    trace_end = te;
    ch_sel = c;
    dump = 1;
    if (c != 3) begin
`ifdef DUMP_HEADER_EN
      byte_q.push_back(8'hA5);
      byte_q.push_back(8'(c));
`endif
      s = te == 383 ? 0 : int'(te) + 1;
      for (int i = 0; i < 384; i++) begin
        rd_q.push_back('{addr: 9'((s + i) % 384), en: 3'(1) << c});
        byte_q.push_back(mem(c, 9'((s + i) % 384)));
      end
    end
    @(negedge clk);
    dump = 0;
  endtask

  task automatic service(input int abort_at, input int inject_at, output int nbytes);
    int cd = 0, cyc = 0;
    bit done = 0;
    rd_t e;
    nbytes = 0;
    while (!done && cyc < 6000) begin
      dump = 0;
      tx_done = cd == 1;
      if (cd > 0) cd--;
      if (ram_en != 0) begin
        chk("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("ram_addr", 32'(ram_addr), 32'(e.addr));
          chk("ram_en", 32'(ram_en), 32'(e.en));
        end
      end
      if (trmt) begin
        chk("trmt_expected", byte_q.size() != 0, 1);
        if (byte_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(byte_q.pop_front()));
        nbytes++;
        cd = 3;
        if (nbytes == inject_at) begin
          dump = 1;
          ch_sel = 2;
          trace_end = 7;
        end
        if (nbytes == abort_at) begin
          rst = 1;
          #1;
          chk("rst_trmt", 32'(trmt), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_ram_en", 32'(ram_en), 0);
          done = 1;
        end
      end
      if (dump_done) begin
        done = 1;
        chk("done_rd_q_empty", rd_q.size(), 0);
        chk("done_byte_q_empty", byte_q.size(), 0);
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("dump_finished", done, 1);
    tx_done = 0;
    dump = 0;
  endtask

  task automatic after_done(input int nbytes);
    chk("byte_count", nbytes, NBYTES);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(dump_done), 0);
  endtask

  initial begin
    int nb, acc;
    rst = 1;
    dump = 0;
    tx_done = 0;
    ch_sel = 0;
    trace_end = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {ram_addr, ram_en, tx_data, trmt, busy, dump_done, dump_err}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_outs", {ram_addr, ram_en, tx_data, trmt, busy, dump_done, dump_err}, 0);

    start_dump(9'd100, 2'd1);
    chk("busy_on_accept", 32'(busy), 1);
    service(0, 0, nb);
    after_done(nb);

    start_dump(9'd383, 2'd0);
    service(0, 0, nb);
    after_done(nb);

    start_dump(9'd5, 2'd3);
    chk("err_pulse", 32'(dump_err), 1);
    chk("err_busy", 32'(busy), 0);
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      acc += int'(ram_en != 0) + int'(trmt) + int'(busy) + int'(dump_err);
    end
    chk("err_quiet", acc, 0);

    start_dump(9'd250, 2'd2);
    service(0, 50, nb);
    after_done(nb);

    start_dump(9'd10, 2'd2);
    service(200, 0, nb);
    @(negedge clk);
    rst = 0;
    rd_q.delete();
    byte_q.delete();
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      acc += int'(dump_done) + int'(busy) + int'(trmt) + int'(ram_en != 0);
    end
    chk("abort_quiet", acc, 0);

    start_dump(9'd0, 2'd1);
    service(0, 0, nb);
    after_done(nb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
